shift_rotate: RTL and testbench

// - Registered 8-bit shift/rotate unit with an integrated result/flag output multiplexer.
// - Sits beside the main ALU. It shifts or rotates src_a by an amount taken from src_b.
// - sel picks the main-ALU result or the shifter result; the chosen pair is registered to alu_result/alu_flags.
// - Flag order is {C, Z, N, V} (bit3..bit0), the same order as the main ALU.

---
 rtl/shift_rotate.sv | 209 ++++++++++++++++++++
 tb/tb_shift_rotate.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/shift_rotate.sv
// Registered 8-bit shift/rotate unit with result/flag select mux; optional carry rotates under SHIFT_ROTATE_CARRY_EN.
// Latency: one cycle (combinational shifter + mux, then one register stage).
// Backpressure: none; a new operation is accepted every cycle.

// Generic 2:1 selector, purely combinational.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Pick d1 when s is high, otherwise d0.
  always_comb begin
    y = s ? d1 : d0;
  end

endmodule

module shift_rotate #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       control,
  input  logic             sel,
  input  logic [WIDTH-1:0] main_res,
  input  logic [3:0]       main_flags,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags
);

  localparam logic [2:0] OP_LSL  = 3'b000;
  localparam logic [2:0] OP_LSR  = 3'b001;
  localparam logic [2:0] OP_ASR  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_RCR  = 3'b110;
  localparam logic [2:0] OP_RCL  = 3'b111;

  localparam logic [AMT_W-1:0] AMT_WIDTH = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] ROT_MASK  = AMT_W'(WIDTH - 1);

  // Registered state.
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [3:0]       alu_flags_q,  alu_flags_d;
  logic             c_q,          c_d;

  // Shift amount; the upper src_b bits carry no meaning for this unit.
  logic [AMT_W-1:0] amt;
  logic [AMT_W-1:0] rot_amt;
  logic             unused_b;

  assign amt      = src_b[AMT_W-1:0];
  assign rot_amt  = amt & ROT_MASK;
  assign unused_b = ^src_b[WIDTH-1:AMT_W];

  // Each shift is done one bit wider so the carry-out falls out of the same operation.
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] rol_res;

  // Plain shifts and rotates, all evaluated in parallel.
  always_comb begin
    lsl_ext = {1'b0, src_a} << amt;
    lsr_ext = {src_a, 1'b0} >> amt;
    asr_ext = $signed({src_a, 1'b0}) >>> amt;
    ror_res = (src_a >> rot_amt) | (src_a << (AMT_WIDTH - rot_amt));
    rol_res = (src_a << rot_amt) | (src_a >> (AMT_WIDTH - rot_amt));
  end

`ifdef SHIFT_ROTATE_CARRY_EN
  // Carry rotates operate on the 9-bit value {C, A}; amount is taken mod 9.
  localparam logic [AMT_W-1:0] RC_LEN = AMT_W'(WIDTH + 1);

  logic [AMT_W-1:0] rc_amt;
  logic [WIDTH:0]   rc_in;
  logic [WIDTH:0]   rcr_ext;
  logic [WIDTH:0]   rcl_ext;

  // 9-bit rotate right/left; a zero amount leaves {C, A} untouched.
  always_comb begin
    rc_amt  = (amt >= RC_LEN) ? (amt - RC_LEN) : amt;
    rc_in   = {c_q, src_a};
    rcr_ext = (rc_in >> rc_amt) | (rc_in << (RC_LEN - rc_amt));
    rcl_ext = (rc_in << rc_amt) | (rc_in >> (RC_LEN - rc_amt));
  end
`endif

  logic [WIDTH-1:0] sh_res;
  logic             sh_cf;
  logic             sh_zf;
  logic             sh_sf;
  logic             sh_of;
  logic             of_en;
  logic             amt_zero;

  // Operation select; a zero amount on any shift/rotate preserves A and the carry.
  always_comb begin
    sh_res   = src_a;
    sh_cf    = c_q;
    of_en    = 1'b1;
    amt_zero = (amt == '0);
    case (control)
      OP_LSL: begin
        sh_res = lsl_ext[WIDTH-1:0];
        sh_cf  = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        sh_res = lsr_ext[WIDTH:1];
        sh_cf  = lsr_ext[0];
      end
      OP_ASR: begin
        sh_res = asr_ext[WIDTH:1];
        sh_cf  = asr_ext[0];
      end
      OP_ROR: begin
        sh_res = ror_res;
        sh_cf  = ror_res[WIDTH-1];
      end
      OP_ROL: begin
        sh_res = rol_res;
        sh_cf  = rol_res[0];
      end
      OP_SWAP: begin
        sh_res = {src_a[WIDTH/2-1:0], src_a[WIDTH-1:WIDTH/2]};
        sh_cf  = c_q;
        of_en  = 1'b0;
      end
`ifdef SHIFT_ROTATE_CARRY_EN
      OP_RCR: begin
        sh_res = rcr_ext[WIDTH-1:0];
        sh_cf  = rcr_ext[WIDTH];
      end
      OP_RCL: begin
        sh_res = rcl_ext[WIDTH-1:0];
        sh_cf  = rcl_ext[WIDTH];
      end
`else
      OP_RCR, OP_RCL: begin
        // Carry rotates not built: pass A through and keep the carry.
        sh_res = src_a;
        sh_cf  = c_q;
        of_en  = 1'b0;
      end
`endif
      default: begin
        sh_res = src_a;
        sh_cf  = c_q;
        of_en  = 1'b0;
      end
    endcase

    // SWAP ignores the amount; the carry rotates already handle a zero amount.
    if (amt_zero && (control <= OP_ROL)) begin
      sh_res = src_a;
      sh_cf  = c_q;
    end

    sh_zf = (sh_res == '0);
    sh_sf = sh_res[WIDTH-1];
    sh_of = of_en & (src_a[WIDTH-1] ^ sh_res[WIDTH-1]);
  end

  // Result and flag selection between main ALU and shifter.
  mux2 #(.WIDTH(WIDTH)) u_res_mux (
    .d0 (main_res),
    .d1 (sh_res),
    .s  (sel),
    .y  (alu_result_d)
  );

  mux2 #(.WIDTH(4)) u_flag_mux (
    .d0 (main_flags),
    .d1 ({sh_cf, sh_zf, sh_sf, sh_of}),
    .s  (sel),
    .y  (alu_flags_d)
  );

  // Carry register follows the shifter only when the shifter path is selected.
  always_comb begin
    c_d = sel ? sh_cf : c_q;
  end

  // Output and carry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q <= '0;
      alu_flags_q  <= '0;
      c_q          <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      alu_flags_q  <= alu_flags_d;
      c_q          <= c_d;
    end
  end

  assign alu_result = alu_result_q;
  assign alu_flags  = alu_flags_q;

endmodule

// File: tb/tb_shift_rotate.sv
// Directed-vector bench for shift_rotate with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
// The unit has no handshake, so every step is exactly one clock.

module tb_shift_rotate;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic [2:0] control;
  logic       sel;
  logic [7:0] main_res;
  logic [3:0] main_flags;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;

  int vectors     = 0;
  int miscompares = 0;

  shift_rotate #(.WIDTH(8), .AMT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_a      (src_a),
    .src_b      (src_b),
    .control    (control),
    .sel        (sel),
    .main_res   (main_res),
    .main_flags (main_flags),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic s, input logic [2:0] ctl,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] mr, input logic [3:0] mf);
    reset      = rst;
    sel        = s;
    control    = ctl;
    src_a      = a;
    src_b      = b;
    main_res   = mr;
    main_flags = mf;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_res, input logic [3:0] exp_flags);
    vectors++;
    assert (alu_result === exp_res) else begin
      miscompares++;
      $error("FAIL %s result: observed %h expected %h", tag, alu_result, exp_res);
    end
    assert (alu_flags === exp_flags) else begin
      miscompares++;
      $error("FAIL %s flags: observed %b expected %b", tag, alu_flags, exp_flags);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; control = 3'b000;
    src_a = 8'h00; src_b = 8'h00; main_res = 8'h00; main_flags = 4'h0;

    // Reset wins over live shifter inputs.
    step(1'b1, 1'b1, 3'b000, 8'h81, 8'h01, 8'hAA, 4'hF);
    check("reset", 8'h00, 4'b0000);
    // SWAP, n=0: carry comes from C, which reset cleared.
    step(1'b0, 1'b1, 3'b101, 8'h3C, 8'h00, 8'h00, 4'h0);
    check("swap_after_reset", 8'hC3, 4'b0010);
    // LSL 81 by 1: C<=1.
    step(1'b0, 1'b1, 3'b000, 8'h81, 8'h01, 8'h00, 4'h0);
    check("lsl_81_1", 8'h02, 4'b1001);
    // Main ALU path passes through; C must hold at 1.
    step(1'b0, 1'b0, 3'b000, 8'hFF, 8'h01, 8'h5A, 4'b0110);
    check("main_path", 8'h5A, 4'b0110);
    // SWAP of zero exposes held C=1 as cf.
    step(1'b0, 1'b1, 3'b101, 8'h00, 8'h05, 8'h00, 4'h0);
    check("swap_c_held", 8'h00, 4'b1100);
    // ASR 80 by 3: C<=0.
    step(1'b0, 1'b1, 3'b010, 8'h80, 8'h03, 8'h00, 4'h0);
    check("asr_80_3", 8'hF0, 4'b0010);
    // ROR 01 by 1: C<=1.
    step(1'b0, 1'b1, 3'b011, 8'h01, 8'h01, 8'h00, 4'h0);
    check("ror_01_1", 8'h80, 4'b1011);
    // LSR FF by 9: everything shifted out, cf=0; C<=0.
    step(1'b0, 1'b1, 3'b001, 8'hFF, 8'h09, 8'h00, 4'h0);
    check("lsr_ff_9", 8'h00, 4'b0101);
    // LSL by 0 keeps A and C=0.
    step(1'b0, 1'b1, 3'b000, 8'hFF, 8'h00, 8'h00, 4'h0);
    check("lsl_n0", 8'hFF, 4'b0010);
    // LSL by 8: cf=A[0]=1; C<=1.
    step(1'b0, 1'b1, 3'b000, 8'h01, 8'h08, 8'h00, 4'h0);
    check("lsl_01_8", 8'h00, 4'b1100);
    // LSR by 8: cf=A[7]=1, of=1.
    step(1'b0, 1'b1, 3'b001, 8'h80, 8'h08, 8'h00, 4'h0);
    check("lsr_80_8", 8'h00, 4'b1101);
    // ASR by 0 keeps A and C=1.
    step(1'b0, 1'b1, 3'b010, 8'h80, 8'h00, 8'h00, 4'h0);
    check("asr_n0", 8'h80, 4'b1010);
    // ASR positive by 15: sign fill 0, cf=0; C<=0.
    step(1'b0, 1'b1, 3'b010, 8'h7F, 8'h0F, 8'h00, 4'h0);
    check("asr_7f_15", 8'h00, 4'b0100);
    // ROL 81 by 1: C<=1.
    step(1'b0, 1'b1, 3'b100, 8'h81, 8'h01, 8'h00, 4'h0);
    check("rol_81_1", 8'h03, 4'b1001);
    // ROR by 8 is a full turn but n!=0, so cf=res[7].
    step(1'b0, 1'b1, 3'b011, 8'h96, 8'h08, 8'h00, 4'h0);
    check("ror_96_8", 8'h96, 4'b1010);
    // Upper src_b bits ignored: n=4; C<=0.
    step(1'b0, 1'b1, 3'b001, 8'hF0, 8'h34, 8'h00, 4'h0);
    check("lsr_b_upper", 8'h0F, 4'b0001);
    // ROL by 12 = 4 mod 8; C<=1.
    step(1'b0, 1'b1, 3'b100, 8'h12, 8'h0C, 8'h00, 4'h0);
    check("rol_12_12", 8'h21, 4'b1000);
`ifdef SHIFT_ROTATE_CARRY_EN
    // RCL {1,00} by 1 -> {0,01}; C<=0.
    step(1'b0, 1'b1, 3'b111, 8'h00, 8'h01, 8'h00, 4'h0);
    check("rcl_c1_00_1", 8'h01, 4'b0000);
    // RCR {0,01} by 1 -> {1,00}; C<=1.
    step(1'b0, 1'b1, 3'b110, 8'h01, 8'h01, 8'h00, 4'h0);
    check("rcr_c0_01_1", 8'h00, 4'b1100);
`else
    // Carry rotates absent: A passes, cf=C=1, of=0.
    step(1'b0, 1'b1, 3'b111, 8'h00, 8'h01, 8'h00, 4'h0);
    check("rcl_off", 8'h00, 4'b1100);
    step(1'b0, 1'b1, 3'b110, 8'h01, 8'h01, 8'h00, 4'h0);
    check("rcr_off", 8'h01, 4'b1000);
`endif
    // Reset again (C was 1), then SWAP n=0 must show cf=0.
    step(1'b1, 1'b0, 3'b000, 8'h00, 8'h00, 8'hFF, 4'b1111);
    check("reset2", 8'h00, 4'b0000);
    step(1'b0, 1'b1, 3'b101, 8'h01, 8'h00, 8'h00, 4'h0);
    check("swap_after_reset2", 8'h10, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
